// File: rtl/risc32_stage_pipe.sv
// risc32_stage_pipe: DEPTH-slot stall-aware register chain with valid bits, flush and saturating bubble counter
module risc32_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 1,
    parameter int STALL_W = 6,
    parameter int STAGE = 3,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [DEPTH-1:0]   slot_valid,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt
);
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d, src_valid;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    nbub, sum;

    // each slot sources from upstream input (slot 0) or the previous slot's pre-edge value
    always_comb begin
        src_data[0] = in_data;
        src_valid[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            src_data[k] = data_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // per-slot flush > bubble > advance > hold, counting bubbles taken this cycle
    always_comb begin
        nbub = '0;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
            valid_d[k] = valid_q[k];
            if (flush) begin
                data_d[k] = NOP_VAL;
                valid_d[k] = 1'b0;
            end else if (stall[STAGE+k] && !stall[STAGE+k+1]) begin
                data_d[k] = NOP_VAL;
                valid_d[k] = 1'b0;
                nbub = nbub + (CNT_W+1)'(1);
            end else if (!stall[STAGE+k]) begin
                data_d[k] = src_data[k];
                valid_d[k] = src_valid[k];
            end
        end
    end

    // bubble counter: clear wins, flush freezes, otherwise saturating add
    always_comb begin
        sum = {1'b0, cnt_q} + nbub;
        cnt_d = cnt_clr ? '0 : flush ? cnt_q : sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= NOP_VAL;
            valid_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
            valid_q <= valid_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_data = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign slot_valid = valid_q;
    assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_risc32_stage_pipe.sv
// tb_risc32_stage_pipe: randomized and directed checks of the stall pipe against a behavioural model
module tb_risc32_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  slot_valid;
    logic        cnt_clr = 1'b0;
    logic [3:0]  bubble_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] m_data [2];
    bit          m_valid [2];
    int          m_cnt;

    risc32_stage_pipe #(.DATA_W(32), .DEPTH(2), .STALL_W(6), .STAGE(3), .NOP_VAL(32'h0), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .slot_valid(slot_valid), .cnt_clr(cnt_clr),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] od [2];
        bit          ov [2];
        int          nb = 0;
        od = m_data;
        ov = m_valid;
        if (!rst) begin
            m_data = '{32'h0, 32'h0};
            m_valid = '{1'b0, 1'b0};
            m_cnt = 0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit si = stall[3+k];
            bit so = stall[4+k];
            if (flush) begin
                m_data[k] = 0;
                m_valid[k] = 0;
            end else if (si && !so) begin
                m_data[k] = 0;
                m_valid[k] = 0;
                nb++;
            end else if (!si) begin
                m_data[k] = (k == 0) ? in_data : od[k-1];
                m_valid[k] = (k == 0) ? in_valid : ov[k-1];
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (!flush) m_cnt = (m_cnt + nb > 15) ? 15 : m_cnt + nb;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("out_data", out_data, m_data[1]);
        chk("out_valid", 32'(out_valid), 32'(m_valid[1]));
        chk("slot_valid", 32'(slot_valid), {30'b0, m_valid[1], m_valid[0]});
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    endtask

    initial begin
        m_data = '{32'h1, 32'h1};
        m_valid = '{1'b1, 1'b1};
        m_cnt = 7;
        rst = 1'b0; in_data = 32'hDEADBEEF; in_valid = 1'b1; stall = '0;
        tick();
        chk("rst_data", out_data, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_slots", 32'(slot_valid), 32'h0);
        chk("rst_cnt", 32'(bubble_cnt), 32'h0);

        rst = 1'b1; in_data = 32'hA5A50001; tick();
        in_data = 32'hA5A50002; tick();
        chk("flow1", out_data, 32'hA5A50001);
        chk("flow1_v", 32'(out_valid), 32'h1);
        in_data = 32'h11; tick();
        chk("flow2", out_data, 32'hA5A50002);

        in_data = 32'h22; tick();
        stall = 6'b001000; in_data = 32'h99; tick();
        chk("bub_s1", out_data, 32'h22);
        chk("bub_slots", 32'(slot_valid), 32'h2);
        chk("bub_cnt", 32'(bubble_cnt), 32'h1);

        stall = 6'b011000; tick();
        chk("hb_slots", 32'(slot_valid), 32'h0);
        chk("hb_cnt", 32'(bubble_cnt), 32'h2);
        stall = 6'b111000; tick();
        chk("hold_cnt", 32'(bubble_cnt), 32'h2);

        stall = '0; in_data = 32'h33; tick();
        in_data = 32'h44; tick();
        chk("pre_flush", 32'(slot_valid), 32'h3);
        flush = 1'b1; stall = 6'b001000; tick();
        chk("flush_data", out_data, 32'h0);
        chk("flush_slots", 32'(slot_valid), 32'h0);
        chk("flush_cnt", 32'(bubble_cnt), 32'h2);
        flush = 1'b0;

        repeat (20) tick();
        chk("sat_cnt", 32'(bubble_cnt), 32'hF);
        cnt_clr = 1'b1; tick();
        chk("clr_cnt", 32'(bubble_cnt), 32'h0);
        cnt_clr = 1'b0;

        repeat (400) begin
            rst = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 11) == 0);
            cnt_clr = ($urandom_range(0, 29) == 0);
            stall = 6'($urandom);
            in_valid = 1'($urandom);
            in_data = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
